// File: rtl/manhattan_nearest_ctrl.sv
// Nearest-point search controller: buffers a query and up to NPTS candidates,
// walks them through the external Manhattan distance unit and reports the closest one.
module manhattan_nearest_ctrl #(
    parameter int NPTS  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [3:0]       dp_a,
    output logic [3:0]       dp_b,
    output logic [2:0]       dp_c,
    output logic [2:0]       dp_d,
    input  logic [3:0]       dp_dist_high,
    input  logic [3:0]       dp_dist_low,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [4:0]       out_dist,
    output logic [IDX_W:0]   out_count,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    // Both streams: a beat transfers on the rising edge where valid & ready are
    // both high; valid never depends on ready, and a held result stays stable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [5:0]       cand_q [NPTS];
    logic [3:0]       qx_q;
    logic [3:0]       qy_q;
    logic [IDX_W:0]   count_q;
    logic [IDX_W-1:0] scan_q;
    logic [4:0]       d_q;
    logic [IDX_W-1:0] i_q;
    logic             v_q;
    logic [4:0]       best_q;
    logic [IDX_W-1:0] best_idx_q;

    logic             accept_d;
    logic             load_end_d;
    logic             scan_last_d;
    logic [4:0]       dist_d;
    logic             unused_hi;

    // The true distance never exceeds 30, so only bit 0 of the high nibble matters.
    assign dist_d      = {dp_dist_high[0], dp_dist_low};
    assign unused_hi   = ^dp_dist_high[3:1];

    assign in_ready    = (state_q == S_LOAD) && (count_q < (IDX_W+1)'(NPTS));
    assign accept_d    = in_valid && in_ready;
    assign load_end_d  = in_last || (count_q == (IDX_W+1)'(NPTS - 1));
    assign scan_last_d = ({1'b0, scan_q} == (count_q - (IDX_W+1)'(1)));

    assign dp_a        = qx_q;
    assign dp_b        = qy_q;
    assign dp_c        = (state_q == S_SCAN) ? cand_q[scan_q][5:3] : 3'd0;
    assign dp_d        = (state_q == S_SCAN) ? cand_q[scan_q][2:0] : 3'd0;

    assign out_valid   = (state_q == S_DONE);
    assign out_idx     = best_idx_q;
    assign out_dist    = best_q;
    assign out_count   = count_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NPTS; i++) cand_q[i] <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            count_q    <= '0;
            scan_q     <= '0;
            d_q        <= '0;
            i_q        <= '0;
            v_q        <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            // Strict less-than keeps the earliest index on ties.
            if (v_q && (d_q < best_q)) begin
                best_q     <= d_q;
                best_idx_q <= i_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        qx_q    <= in_data[7:4];
                        qy_q    <= in_data[3:0];
                        count_q <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept_d) begin
                        cand_q[count_q[IDX_W-1:0]] <= in_data[5:0];
                        count_q <= count_q + (IDX_W+1)'(1);
                        if (load_end_d) begin
                            scan_q     <= '0;
                            best_q     <= 5'd31;
                            best_idx_q <= '0;
                            v_q        <= 1'b0;
                            state_q    <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    d_q    <= dist_d;
                    i_q    <= scan_q;
                    v_q    <= 1'b1;
                    scan_q <= scan_q + IDX_W'(1);
                    if (scan_last_d) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    v_q     <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manhattan_nearest_ctrl.sv
// Bench for manhattan_nearest_ctrl: random and directed searches scored against
// an arithmetic nearest-point model, with a behavioural distance unit.
module tb_manhattan_nearest_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [3:0] dp_a;
    logic [3:0] dp_b;
    logic [2:0] dp_c;
    logic [2:0] dp_d;
    logic [3:0] dp_dist_high;
    logic [3:0] dp_dist_low;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [4:0] out_dist;
    logic [3:0] out_count;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];
    logic [5:0]  cand [8];
    int dist_m;

    manhattan_nearest_ctrl #(.NPTS(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_dist_high(dp_dist_high), .dp_dist_low(dp_dist_low),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_dist(out_dist), .out_count(out_count), .busy(busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mdist(input int ax, input int ay, input int bx, input int by);
        int dx;
        int dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return dx + dy;
    endfunction

    // Behavioural distance unit on the shared datapath.
    always_comb begin
        dist_m       = mdist(int'(dp_a), int'(dp_b), int'(dp_c), int'(dp_d));
        dp_dist_high = 4'(dist_m / 16);
        dp_dist_low  = 4'(dist_m % 16);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: minimum distance, then the first candidate that reaches it.
    task automatic model_push(input logic [3:0] qx, input logic [3:0] qy, input int n);
        int d [8];
        int mn;
        int idx;
        mn = 1000;
        for (int i = 0; i < n; i++) begin
            d[i] = mdist(int'(qx), int'(qy), int'(cand[i][5:3]), int'(cand[i][2:0]));
            if (d[i] <= mn) mn = d[i];
        end
        idx = -1;
        for (int i = n - 1; i >= 0; i--) if (d[i] == mn) idx = i;
        exp_q.push_back({3'(idx), 5'(mn), 4'(n)});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {in_ready, out_valid, out_idx, out_dist, out_count, busy,
                       dp_a, dp_b, dp_c, dp_d}, 32'd0);
        check_eq({tag, "_state"}, dbg_state, 32'd0);
    endtask

    task automatic load_cands(input logic [3:0] qx, input logic [3:0] qy, input int n,
                              input bit use_last, input bit bubbles);
        @(negedge clk);
        start   = 1'b1;
        in_data = {qx, qy};
        @(negedge clk);
        start = 1'b0;
        check_eq("ready_after_start", in_ready, 1);
        for (int i = 0; i < n; i++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(0, 1));
                    in_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = {2'($urandom_range(0, 3)), cand[i]};
            in_last  = use_last && (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_search(input logic [3:0] qx, input logic [3:0] qy, input int n,
                              input bit use_last, input bit bubbles, input bit hold);
        int lat;
        logic [11:0] exp_v;
        logic [11:0] got;
        int d0;
        model_push(qx, qy, n);
        load_cands(qx, qy, n, use_last, bubbles);
        check_eq("ready_drop", in_ready, 0);
        d0 = mdist(int'(qx), int'(qy), int'(cand[0][5:3]), int'(cand[0][2:0]));
        check_eq("dp_cd_scan0", {dp_c, dp_d}, cand[0]);
        check_eq("dp_ab_query", {dp_a, dp_b}, {qx, qy});
        check_eq("dp_dist_scan0", {dp_dist_high, dp_dist_low}, 8'(d0));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, n + 1);
        if (!out_valid) begin
            void'(exp_q.pop_front());
            apply_reset();
            return;
        end
        got = {out_idx, out_dist, out_count};
        if (exp_q.size() == 0) begin
            check_eq("sb_nonempty", 0, 1);
        end else begin
            exp_v = exp_q.pop_front();
            check_eq("out_idx", out_idx, exp_v[11:9]);
            check_eq("out_dist", out_dist, exp_v[8:4]);
            check_eq("out_count", out_count, exp_v[3:0]);
        end
        if (hold) begin
            repeat (5) begin
                start   = 1'b1;
                in_data = 8'($urandom);
                @(negedge clk);
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_outs", {out_idx, out_dist, out_count}, got);
                check_eq("hold_query", {dp_a, dp_b}, {qx, qy});
            end
            start = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("busy_after_ack", busy, 0);
        check_eq("valid_after_ack", out_valid, 0);
    endtask

    initial begin
        int n;
        bit use_last;
        rst       = 1'b1;
        start     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset_vals");
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("idle_ignores_valid", busy, 0);

        // Basic search with response hold and ignored start.
        cand[0] = {3'd1, 3'd1}; cand[1] = {3'd4, 3'd6}; cand[2] = {3'd7, 3'd7};
        run_search(4'd5, 4'd5, 3, 1'b1, 1'b0, 1'b1);

        // Tie keeps the lower index.
        cand[0] = {3'd2, 3'd1}; cand[1] = {3'd1, 3'd2};
        run_search(4'd0, 4'd0, 2, 1'b1, 1'b0, 1'b0);

        // Full buffer, no in_last, distances 14 down to 7.
        cand[0] = {3'd7, 3'd7}; cand[1] = {3'd7, 3'd6}; cand[2] = {3'd6, 3'd6};
        cand[3] = {3'd6, 3'd5}; cand[4] = {3'd5, 3'd5}; cand[5] = {3'd5, 3'd4};
        cand[6] = {3'd4, 3'd4}; cand[7] = {3'd4, 3'd3};
        run_search(4'd0, 4'd0, 8, 1'b0, 1'b0, 1'b0);

        // Largest distance exercises the high bit of the distance unit.
        cand[0] = {3'd0, 3'd0};
        run_search(4'd15, 4'd15, 1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a scan.
        for (int i = 0; i < 6; i++) cand[i] = 6'($urandom);
        load_cands(4'd9, 4'd2, 6, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outs("reset_mid_scan");
        @(negedge clk);
        rst = 1'b0;
        cand[0] = {3'd3, 3'd3};
        run_search(4'd3, 4'd3, 1, 1'b1, 1'b0, 1'b0);

        // Random searches with input bubbles.
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) cand[i] = 6'($urandom);
            use_last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            run_search(4'($urandom), 4'($urandom), n, use_last, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/manhattan_nearest_ctrl.md
# manhattan_nearest_ctrl

Nearest-point search controller for the shared Manhattan-distance datapath in the Mini SPU. It accepts a 4-bit query point and up to NPTS 3-bit candidate points over a valid/ready stream and buffers the candidates in a local register file. It then walks the buffer through the external distance unit one point per cycle and returns the index and distance of the closest candidate on a valid/ready result port. The distance unit stays combinational and outside this block; this block only drives its operands and consumes its result.

## Interface
- NPTS, 8: candidate buffer depth, range 2..8.
- IDX_W, 3: index width, equal to clog2(NPTS).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sampled only in IDLE; latches qx = in_data[7:4] and qy = in_data[3:0].
- in_data  in  8  on start: the query; in LOAD: candidate, cx = in_data[5:3], cy = in_data[2:0]; bits [7:6] ignored.
- in_valid  in  1  candidate valid.
- in_last  in  1  qualifies in_valid; marks the final candidate.
- in_ready  out  1  high in LOAD while count < NPTS.
- dp_a, dp_b  out  4  query x/y to the distance unit (registered qx/qy).
- dp_c, dp_d  out  3  candidate x/y to the distance unit.
- dp_dist_high, dp_dist_low  in  4  distance unit result.
- out_valid  out  1  result available.
- out_ready  in  1  result consumer ready.
- out_idx  out  IDX_W  index of the nearest candidate, in arrival order starting at 0.
- out_dist  out  5  minimum distance, range 0..30.
- out_count  out  IDX_W+1  number of candidates searched.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, SCAN, FLUSH, DONE.
- IDLE:
  - start=1 latches qx/qy, clears count, and moves to LOAD.
  - in_valid is ignored.
- LOAD:
  - A transfer occurs when in_valid & in_ready. It writes buf[count] and increments count.
  - The block moves to SCAN when the accepted transfer has in_last=1, or when it is the NPTS-th transfer, whichever comes first.
  - in_last without in_valid has no effect. start is ignored.
- SCAN:
  - scan_idx counts 0..count-1. Each cycle drives dp_c/dp_d = buf[scan_idx].
  - Each edge registers d_q = {dp_dist_high[0], dp_dist_low} and i_q = scan_idx, and sets v_q=1.
  - After the edge that registers index count-1, the block moves to FLUSH.
- Compare stage, every edge where v_q=1: if d_q < best (strictly less), then best <= d_q and best_idx <= i_q.
  - best is initialised to 31 on entry to SCAN.
  - Ties therefore keep the lowest index.
- FLUSH: performs the final compare, clears v_q, and moves to DONE.
- DONE:
  - out_valid=1, with out_idx/out_dist/out_count held stable.
  - out_valid & out_ready moves to IDLE. start is ignored until then.
- dp_c/dp_d = 0 outside SCAN. dp_a/dp_b always show qx/qy.
- Width rule: the true distance is ≤ 30, so dp_dist_high[3:1] is always 0. Only bit 0 is used.
- Reset at any point returns the block to IDLE and discards the buffer and any partial search.

## Timing
- Reset values: in_ready=0, out_valid=0, out_idx=0, out_dist=0, out_count=0, busy=0, dp_a=dp_b=0, dp_c=dp_d=0, state IDLE.
- start edge → in_ready=1 on the next cycle.
- Sustained throughput: one candidate per cycle. Bubbles on in_valid are allowed.
- Last candidate accepted at edge E → SCAN occupies cycles E+1..E+N → out_valid rises after edge E+N+1.
- Total latency from the last accept to out_valid is therefore N+1 cycles.
- in_ready drops in the cycle after the final accept.
- When out_valid & out_ready at edge F: busy=0 after F, and a new start is accepted at F+1 at the earliest.

## Test plan
- Basic search: query (5,5); candidates (1,1), (4,6), (7,7)+last → out_idx=1, out_dist=2, out_count=3; out_valid exactly 4 edges after the last accept.
- Tie-break: query (0,0); candidates (2,1), (1,2)+last → out_idx=0, out_dist=3.
- Buffer full: NPTS=8, candidates with distances 14 down to 7 and no in_last → in_ready low after the 8th accept; out_idx=7, out_dist=7, out_count=8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse start meanwhile → outputs stable, start ignored; release → IDLE, busy=0.
- Width extreme: query (15,15), candidate (0,0)+last → out_dist=30; dp_dist_high=1 and dp_dist_low=14 observed on the ports.
- Reset mid-SCAN: assert rst during scan_idx=2 → all outputs at reset values immediately; a following query (3,3) with candidate (3,3)+last → out_dist=0, out_idx=0.
